// File: rtl/vga_pxl_write_arbiter.sv
// Framebuffer write-port arbiter: merges single-pixel CPU writes and a
// rectangle-fill engine onto one registered, back-pressured RAM write slot.
module vga_pxl_write_arbiter #(
  parameter int unsigned X_W    = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_wr,
  input  logic [2*X_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]   cpu_data,
  output logic                cpu_busy,
  output logic                cpu_drop,
  input  logic                fill_start,
  input  logic                fill_abort,
  input  logic [X_W-1:0]      fill_x0,
  input  logic [X_W-1:0]      fill_y0,
  input  logic [X_W:0]        fill_w,
  input  logic [X_W:0]        fill_h,
  input  logic [DATA_W-1:0]   fill_color,
  output logic                fill_busy,
  output logic                fill_done,
  output logic                fb_we,
  output logic [2*X_W-1:0]    fb_addr,
  output logic [DATA_W-1:0]   fb_data,
  input  logic                fb_ready
);

  localparam int unsigned ADDR_W = 2 * X_W;
  localparam int unsigned SZ_W   = X_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_cpu_busy;
  logic                r_cpu_drop;
  logic [ADDR_W-1:0]   r_cpu_addr;
  logic [DATA_W-1:0]   r_cpu_data;

  logic                r_fb_we;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [DATA_W-1:0]   r_fb_data;
  logic                r_slot_cpu;
  logic                r_pri_cpu;

  logic [X_W-1:0]      r_x0;
  logic [X_W-1:0]      r_y0;
  logic [SZ_W-1:0]     r_w;
  logic [SZ_W-1:0]     r_h;
  logic [DATA_W-1:0]   r_color;
  logic [SZ_W-1:0]     r_i;
  logic [SZ_W-1:0]     r_j;
  logic                r_issued_all;
  logic                r_abort;

  logic                w_xfer;
  logic                w_slot_free;
  logic                w_cpu_pend;
  logic                w_fill_pend;
  logic                w_gnt_cpu;
  logic                w_gnt_fill;
  logic                w_fill_inflight;
  logic                w_fill_busy;
  logic                w_fill_done;
  logic [X_W-1:0]      w_fx;
  logic [X_W-1:0]      w_fy;

  // Slot is free when empty or draining this cycle; a loaded CPU write is no longer pending.
  assign w_xfer          = r_fb_we & fb_ready;
  assign w_slot_free     = ~r_fb_we | fb_ready;
  assign w_cpu_pend      = r_cpu_busy & ~(r_fb_we & r_slot_cpu);
  assign w_fill_pend     = (r_state == S_RUN) & ~r_issued_all & ~r_abort & ~fill_abort;
  assign w_gnt_cpu       = w_slot_free & w_cpu_pend & (~w_fill_pend | r_pri_cpu);
  assign w_gnt_fill      = w_slot_free & w_fill_pend & ~w_gnt_cpu;
  assign w_fill_inflight = r_fb_we & ~r_slot_cpu & ~fb_ready;

  // Coordinates wrap modulo 128 by truncation.
  assign w_fx = r_x0 + r_i[X_W-1:0];
  assign w_fy = r_y0 + r_j[X_W-1:0];

  // Fill FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fill FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (fill_start) w_state_nxt = (fill_w == '0 || fill_h == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if ((r_issued_all | r_abort | fill_abort) & ~w_gnt_fill & ~w_fill_inflight)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fill FSM outputs
  always_comb begin
    w_fill_busy = 1'b0;
    w_fill_done = 1'b0;
    unique case (r_state)
      S_RUN:   w_fill_busy = 1'b1;
      S_DONE: begin
        w_fill_busy = 1'b1;
        w_fill_done = 1'b1;
      end
      default: ;
    endcase
  end

  // CPU holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_busy <= 1'b0;
      r_cpu_drop <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_data <= '0;
    end else begin
      r_cpu_drop <= cpu_wr & r_cpu_busy;
      if (cpu_wr & ~r_cpu_busy) begin
        r_cpu_busy <= 1'b1;
        r_cpu_addr <= cpu_addr;
        r_cpu_data <= cpu_data;
      end else if (w_xfer & r_slot_cpu) begin
        r_cpu_busy <= 1'b0;
      end
    end
  end

  // Output slot and round-robin pointer (r_pri_cpu: CPU wins the next tie)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
      r_slot_cpu <= 1'b0;
      r_pri_cpu  <= 1'b1;
    end else if (w_slot_free) begin
      r_fb_we <= w_gnt_cpu | w_gnt_fill;
      if (w_gnt_cpu) begin
        r_fb_addr  <= r_cpu_addr;
        r_fb_data  <= r_cpu_data;
        r_slot_cpu <= 1'b1;
        r_pri_cpu  <= 1'b0;
      end else if (w_gnt_fill) begin
        r_fb_addr  <= {w_fy, w_fx};
        r_fb_data  <= r_color;
        r_slot_cpu <= 1'b0;
        r_pri_cpu  <= 1'b1;
      end
    end
  end

  // Fill parameters and raster counters; counters move only on a fill grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0         <= '0;
      r_y0         <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_color      <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_issued_all <= 1'b0;
      r_abort      <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (fill_start) begin
        r_x0         <= fill_x0;
        r_y0         <= fill_y0;
        r_w          <= fill_w;
        r_h          <= fill_h;
        r_color      <= fill_color;
        r_i          <= '0;
        r_j          <= '0;
        r_issued_all <= 1'b0;
        r_abort      <= 1'b0;
      end
    end else if (r_state == S_RUN) begin
      if (fill_abort) r_abort <= 1'b1;
      if (w_gnt_fill) begin
        if (r_i == r_w - SZ_W'(1)) begin
          r_i <= '0;
          r_j <= r_j + SZ_W'(1);
          if (r_j == r_h - SZ_W'(1)) r_issued_all <= 1'b1;
        end else begin
          r_i <= r_i + SZ_W'(1);
        end
      end
    end
  end

  assign cpu_busy  = r_cpu_busy;
  assign cpu_drop  = r_cpu_drop;
  assign fill_busy = w_fill_busy;
  assign fill_done = w_fill_done;
  assign fb_we     = r_fb_we;
  assign fb_addr   = r_fb_addr;
  assign fb_data   = r_fb_data;

endmodule
